// File: rtl/intr_ctrl_if.sv
// Purpose: groups the pipeline, stack and data-port signals of the interrupt controller.
// Latency: none, wiring only.
// Backpressure: none; the controller stalls fetch through the write enables it drives.
interface intr_ctrl_if;
  logic       intr_sig;
  logic       boundary;
  logic       rti_dec;
  logic [7:0] pc_current;
  logic [7:0] sp_val;
  logic [3:0] ccr_in;
  logic [7:0] mem_rdata;

  logic       pc_write_en;
  logic       if_id_write_en;
  logic       inject_bubble;
  logic       sp_en;
  logic       sp_op;
  logic       mem_rd;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       pc_load;
  logic [7:0] pc_load_val;
  logic       ccr_load;
  logic [3:0] ccr_val;
  logic       busy;
  logic       int_ack;

  // Controller side.
  modport master (
    input  intr_sig, boundary, rti_dec, pc_current, sp_val, ccr_in, mem_rdata,
    output pc_write_en, if_id_write_en, inject_bubble, sp_en, sp_op, mem_rd, mem_we,
           mem_addr, mem_wdata, pc_load, pc_load_val, ccr_load, ccr_val, busy, int_ack
  );

  // CPU / memory side.
  modport slave (
    output intr_sig, boundary, rti_dec, pc_current, sp_val, ccr_in, mem_rdata,
    input  pc_write_en, if_id_write_en, inject_bubble, sp_en, sp_op, mem_rd, mem_we,
           mem_addr, mem_wdata, pc_load, pc_load_val, ccr_load, ccr_val, busy, int_ack
  );
endinterface

// File: rtl/intr_ctrl.sv
// Purpose: single-level interrupt entry (drain, push PC, vector fetch) and RTI return (drain, pop PC, restore CCR).
// Latency: int_ack comes 1 + DRAIN_CYCLES + 3 cycles after an intr_sig edge seen at a boundary.
// Backpressure: holds fetch via pc_write_en/if_id_write_en and bubbles ID/EX while draining; edges only set pending.
module intr_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic [7:0]  VEC_ADDR     = 8'h01
) (
  input logic         clk,
  input logic         rst,
  intr_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, DRAIN, PUSH, VEC_RD, VEC_LD, ISR, R_DRAIN, POP, R_WAIT, R_LD
  } state_t;

  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);

  state_t     state;
  logic       pending;
  logic       intr_prev;
  logic [7:0] ret_pc;
  logic [3:0] shadow;
  logic [2:0] drain_cnt;
  logic       intr_edge;

  assign intr_edge = bus.intr_sig & ~intr_prev;

  // Edge detect, pending flag (set beats the PUSH clear), sequencing state and captured context.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= 1'b0;
      intr_prev <= 1'b0;
      ret_pc    <= 8'h00;
      shadow    <= 4'h0;
      drain_cnt <= 3'd0;
    end else begin
      intr_prev <= bus.intr_sig;
      if (intr_edge) begin
        pending <= 1'b1;
      end else if (state == PUSH) begin
        pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pending && bus.boundary) begin
            state     <= DRAIN;
            ret_pc    <= bus.pc_current;
            shadow    <= bus.ccr_in;
            drain_cnt <= DRAIN_INIT;
          end
        end
        DRAIN: begin
          if (drain_cnt == 3'd0) state <= PUSH;
          else                   drain_cnt <= drain_cnt - 3'd1;
        end
        PUSH:   state <= VEC_RD;
        VEC_RD: state <= VEC_LD;
        VEC_LD: state <= ISR;
        ISR: begin
          // Only place rti_dec is honoured; new interrupts stay pending until IDLE.
          if (bus.rti_dec) begin
            state     <= R_DRAIN;
            drain_cnt <= DRAIN_INIT;
          end
        end
        R_DRAIN: begin
          if (drain_cnt == 3'd0) state <= POP;
          else                   drain_cnt <= drain_cnt - 3'd1;
        end
        POP: state <= R_WAIT;
        R_WAIT: begin
          ret_pc <= bus.mem_rdata;
          state  <= R_LD;
        end
        R_LD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode per state; reset forces the idle pattern so nothing leaks in the reset cycle.
  always_comb begin
    bus.pc_write_en    = 1'b0;
    bus.if_id_write_en = 1'b0;
    bus.inject_bubble  = 1'b0;
    bus.sp_en          = 1'b0;
    bus.sp_op          = 1'b0;
    bus.mem_rd         = 1'b0;
    bus.mem_we         = 1'b0;
    bus.mem_addr       = 8'h00;
    bus.mem_wdata      = 8'h00;
    bus.pc_load        = 1'b0;
    bus.pc_load_val    = 8'h00;
    bus.ccr_load       = 1'b0;
    bus.ccr_val        = 4'h0;
    bus.busy           = 1'b0;
    bus.int_ack        = 1'b0;
    if (rst) begin
      bus.pc_write_en    = 1'b1;
      bus.if_id_write_en = 1'b1;
    end else begin
      bus.busy = (state != IDLE) && (state != ISR);
      case (state)
        IDLE, ISR: begin
          bus.pc_write_en    = 1'b1;
          bus.if_id_write_en = 1'b1;
        end
        DRAIN, R_DRAIN: bus.inject_bubble = 1'b1;
        PUSH: begin
          bus.mem_we    = 1'b1;
          bus.mem_addr  = bus.sp_val;
          bus.mem_wdata = ret_pc;
          bus.sp_en     = 1'b1;
        end
        VEC_RD: begin
          bus.mem_rd   = 1'b1;
          bus.mem_addr = VEC_ADDR;
        end
        VEC_LD: begin
          bus.pc_load     = 1'b1;
          bus.pc_load_val = bus.mem_rdata;
          bus.int_ack     = 1'b1;
        end
        POP: begin
          bus.mem_rd   = 1'b1;
          bus.mem_addr = bus.sp_val + 8'd1;
          bus.sp_en    = 1'b1;
          bus.sp_op    = 1'b1;
        end
        R_LD: begin
          bus.pc_load     = 1'b1;
          bus.pc_load_val = ret_pc;
          bus.ccr_load    = 1'b1;
          bus.ccr_val     = shadow;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Purpose: directed and randomized checking of intr_ctrl against a cycle-offset model of the entry/return sequences.
// Latency: outputs compared every cycle, just after the falling edge.
// Backpressure: not applicable; the bench drives all inputs and models data memory.
module tb_intr_ctrl;
  localparam int D = 3;
  localparam logic [38:0] IDLE_VEC = 39'h60_0000_0000;
  localparam int B_PCW = 38, B_BUB = 36, B_SPEN = 35, B_SPOP = 34, B_RD = 33, B_WE = 32;
  localparam int B_PCL = 15, B_CCRL = 6, B_BUSY = 1, B_ACK = 0;
  localparam int M_IDLE = 0, M_ENTRY = 1, M_ISR = 2, M_RET = 3;

  logic clk;
  logic rst;
  intr_ctrl_if bus();

  intr_ctrl #(.DRAIN_CYCLES(D), .VEC_ADDR(8'h01)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0]  mem [256];
  logic [38:0] hist [$];

  // Model state: which sequence we are in and how many cycles into it.
  int         m_mode, m_off;
  logic       m_pending, m_prev;
  logic [7:0] m_ret;
  logic [3:0] m_shadow;

  // Inputs sampled before the rising edge, used to advance the model.
  logic       s_rst, s_sig, s_bnd, s_rti;
  logic [7:0] s_pc, s_sp, s_rdata;
  logic [3:0] s_ccr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory seen by the controller; read data is valid the cycle after mem_rd.
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= bus.mem_rd ? mem[bus.mem_addr] : 8'($urandom);
  end

  function automatic logic [38:0] pack_act();
    return {bus.pc_write_en, bus.if_id_write_en, bus.inject_bubble, bus.sp_en, bus.sp_op,
            bus.mem_rd, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.pc_load, bus.pc_load_val,
            bus.ccr_load, bus.ccr_val, bus.busy, bus.int_ack};
  endfunction

  function automatic logic [38:0] model_exp(input logic r, input logic [7:0] sp, input logic [7:0] rdata);
    logic [38:0] e;
    e = '0;
    if (r || m_mode == M_IDLE || m_mode == M_ISR) begin
      e[38] = 1'b1;
      e[37] = 1'b1;
    end else if (m_mode == M_ENTRY) begin
      e[B_BUSY] = 1'b1;
      if (m_off < D) e[B_BUB] = 1'b1;
      else if (m_off == D) begin
        e[B_WE] = 1'b1; e[31:24] = sp; e[23:16] = m_ret; e[B_SPEN] = 1'b1;
      end else if (m_off == D + 1) begin
        e[B_RD] = 1'b1; e[31:24] = 8'h01;
      end else begin
        e[B_PCL] = 1'b1; e[14:7] = rdata; e[B_ACK] = 1'b1;
      end
    end else begin
      e[B_BUSY] = 1'b1;
      if (m_off < D) e[B_BUB] = 1'b1;
      else if (m_off == D) begin
        e[B_RD] = 1'b1; e[31:24] = sp + 8'd1; e[B_SPEN] = 1'b1; e[B_SPOP] = 1'b1;
      end else if (m_off == D + 2) begin
        e[B_PCL] = 1'b1; e[14:7] = m_ret; e[B_CCRL] = 1'b1; e[5:2] = m_shadow;
      end
    end
    return e;
  endfunction

  task automatic model_step();
    logic pend_old, edge_seen;
    if (s_rst) begin
      m_mode = M_IDLE; m_off = 0; m_pending = 1'b0; m_prev = 1'b0; m_ret = 8'h00; m_shadow = 4'h0;
      return;
    end
    pend_old  = m_pending;
    edge_seen = s_sig && !m_prev;
    m_prev    = s_sig;
    if (edge_seen) m_pending = 1'b1;
    else if (m_mode == M_ENTRY && m_off == D) m_pending = 1'b0;
    case (m_mode)
      M_IDLE: if (pend_old && s_bnd) begin
        m_mode = M_ENTRY; m_off = 0; m_ret = s_pc; m_shadow = s_ccr;
      end
      M_ENTRY: if (m_off == D + 2) m_mode = M_ISR; else m_off++;
      M_ISR: if (s_rti) begin m_mode = M_RET; m_off = 0; end
      default: begin
        if (m_off == D + 1) m_ret = s_rdata;
        if (m_off == D + 2) m_mode = M_IDLE; else m_off++;
      end
    endcase
  endtask

  // One clock: compare outputs against the model, log them, then advance the model.
  task automatic tick();
    logic [38:0] act, exp;
    #1;
    s_rst = rst; s_sig = bus.intr_sig; s_bnd = bus.boundary; s_rti = bus.rti_dec;
    s_pc = bus.pc_current; s_sp = bus.sp_val; s_ccr = bus.ccr_in; s_rdata = bus.mem_rdata;
    act = pack_act();
    exp = model_exp(s_rst, s_sp, s_rdata);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL outs cyc=%0d act=%h exp=%h", cyc, act, exp);
    end
    hist.push_back(act);
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic int cnt(input int lo, input int hi, input int b);
    logic [38:0] h;
    int n = 0;
    for (int i = lo; i <= hi && i < hist.size(); i++) begin
      h = hist[i];
      if (h[b]) n++;
    end
    return n;
  endfunction

  function automatic int first_set(input int from, input int b);
    logic [38:0] h;
    for (int i = from; i < hist.size(); i++) begin
      h = hist[i];
      if (h[b]) return i;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; bus.intr_sig = 1'b0; bus.rti_dec = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [38:0] h;
    int rld, bub;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[1] = 8'h40;
    m_mode = M_IDLE; m_off = 0; m_pending = 1'b0; m_prev = 1'b0; m_ret = 8'h00; m_shadow = 4'h0;
    rst = 1'b1;
    bus.intr_sig = 1'b0; bus.boundary = 1'b1; bus.rti_dec = 1'b0;
    bus.pc_current = 8'h20; bus.sp_val = 8'hFF; bus.ccr_in = 4'b0101;

    repeat (3) tick();
    chk("reset_outs", 64'(hist[hist.size() - 1]), 64'(IDLE_VEC));
    rst = 1'b0;
    repeat (2) tick();

    // Interrupt entry from a clean IDLE.
    hist.delete();
    bus.intr_sig = 1'b1; tick(); bus.intr_sig = 1'b0;
    repeat (9) tick();
    chk("entry_bubbles", 64'(cnt(0, 9, B_BUB)), 64'd3);
    h = hist[5];
    chk("push_we_addr_data", {h[B_WE], h[31:24], h[23:16]}, {1'b1, 8'hFF, 8'h20});
    chk("push_sp", {h[B_SPEN], h[B_SPOP]}, 2'b10);
    h = hist[6];
    chk("vec_rd", {h[B_RD], h[31:24]}, {1'b1, 8'h01});
    chk("ack_latency", 64'(first_set(0, B_ACK)), 64'(1 + D + 3));
    h = hist[7];
    chk("vec_load", {h[B_PCL], h[14:7]}, {1'b1, 8'h40});
    chk("isr_outs", 64'(hist[8]), 64'(IDLE_VEC));

    // Return from interrupt.
    hist.delete();
    bus.sp_val = 8'hFE;
    bus.rti_dec = 1'b1; tick(); bus.rti_dec = 1'b0;
    repeat (7) tick();
    chk("ret_bubbles", 64'(cnt(0, 7, B_BUB)), 64'd3);
    h = hist[4];
    chk("pop", {h[B_RD], h[B_SPEN], h[B_SPOP], h[31:24]}, {3'b111, 8'hFF});
    h = hist[6];
    chk("r_ld", {h[B_PCL], h[14:7], h[B_CCRL], h[5:2]}, {1'b1, 8'h20, 1'b1, 4'b0101});
    chk("ret_idle", 64'(hist[7]), 64'(IDLE_VEC));

    // Edge during ISR waits until the return completes.
    bus.sp_val = 8'hFF; bus.pc_current = 8'h33; bus.ccr_in = 4'b1010;
    bus.intr_sig = 1'b1; tick(); bus.intr_sig = 1'b0;
    repeat (9) tick();
    hist.delete();
    bus.intr_sig = 1'b1; tick(); bus.intr_sig = 1'b0;
    repeat (3) tick();
    bus.rti_dec = 1'b1; tick(); bus.rti_dec = 1'b0;
    repeat (12) tick();
    rld = first_set(0, B_CCRL);
    bub = first_set(rld + 1, B_BUB);
    chk("nested_no_push", 64'(cnt(0, rld, B_WE)), 64'd0);
    chk("nested_no_ack", 64'(cnt(0, rld, B_ACK)), 64'd0);
    chk("reentry_gap", 64'(bub - rld), 64'd2);
    do_reset();

    // A level held high yields exactly one sequence.
    hist.delete();
    bus.intr_sig = 1'b1;
    repeat (20) tick();
    bus.intr_sig = 1'b0;
    repeat (5) tick();
    chk("held_level_acks", 64'(cnt(0, 24, B_ACK)), 64'd1);
    chk("held_level_pushes", 64'(cnt(0, 24, B_WE)), 64'd1);
    do_reset();

    // Reset landing on the PUSH cycle.
    tick();
    hist.delete();
    bus.intr_sig = 1'b1;
    repeat (5) tick();
    rst = 1'b1; bus.intr_sig = 1'b0;
    tick();
    rst = 1'b0;
    repeat (6) tick();
    h = hist[5];
    chk("rst_push_we", 64'(h[B_WE]), 64'd0);
    chk("rst_push_outs", 64'(h), 64'(IDLE_VEC));
    chk("rst_pending_clr", 64'(cnt(6, 11, B_BUB) + cnt(6, 11, B_BUSY)), 64'd0);

    // Pending waits for a boundary.
    bus.boundary = 1'b0;
    hist.delete();
    bus.intr_sig = 1'b1; tick(); bus.intr_sig = 1'b0;
    repeat (5) tick();
    bus.boundary = 1'b1;
    repeat (3) tick();
    chk("no_boundary_idle", 64'(cnt(0, 6, B_BUB) + cnt(0, 6, B_BUSY)), 64'd0);
    h = hist[7];
    chk("drain_on_boundary", 64'(h[B_BUB]), 64'd1);
    do_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      hist.delete();
      if ($urandom_range(0, 7) == 0) bus.intr_sig = ~bus.intr_sig;
      bus.boundary   = 1'($urandom_range(0, 1));
      bus.rti_dec    = ($urandom_range(0, 9) == 0);
      rst            = ($urandom_range(0, 299) == 0);
      bus.pc_current = 8'($urandom);
      bus.sp_val     = 8'($urandom);
      bus.ccr_in     = 4'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 DRAIN_CYCLES, 3, number of bubble cycles used to empty the pipeline before a push or after RTI decode (legal range 1-7).
REQ-002 VEC_ADDR, 8'h01, memory address that holds the ISR start address.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 intr_sig  in  1  external interrupt request, level input, edge-detected internally.
REQ-006 boundary  in  1  high when the instruction in IF may be interrupted.
REQ-007 rti_dec  in  1  high for one cycle when an RTI is decoded.
REQ-008 pc_current  in  8  current PC value.
REQ-009 sp_val  in  8  current stack pointer (R3) value.
REQ-010 ccr_in  in  4  current CCR flags {V,C,N,Z}.
REQ-011 mem_rdata  in  8  data-port read data, valid the cycle after mem_rd.
REQ-012 pc_write_en, if_id_write_en  out  1 each  fetch enables, ANDed with CU/HU enables outside this block.
REQ-013 inject_bubble  out  1  forces a NOP into ID/EX.
REQ-014 sp_en, sp_op  out  1 each  SP update strobe; sp_op 0 = decrement (push), 1 = increment (pop).
REQ-015 mem_rd, mem_we  out  1 each  data-port read and write strobes.
REQ-016 mem_addr, mem_wdata  out  8 each  data-port address and write data.
REQ-017 pc_load  out  1  overrides the PC mux with pc_load_val.
REQ-018 pc_load_val  out  8  PC value to load.
REQ-019 ccr_load  out  1  restores the CCR from ccr_val.
REQ-020 ccr_val  out  4  flags to restore.
REQ-021 busy  out  1  high in every state except IDLE and ISR.
REQ-022 int_ack  out  1  one-cycle pulse when the ISR vector is loaded.

Function
REQ-023 The block SHALL hold an internal intr_prev register and SHALL set a pending flag on an intr_sig 0->1 transition.
- If the set and the clear occur in the same cycle, the set SHALL win.
REQ-024 The FSM states SHALL be IDLE, DRAIN, PUSH, VEC_RD, VEC_LD, ISR, R_DRAIN, POP, R_WAIT and R_LD.
REQ-025 IDLE -> DRAIN when pending=1 and boundary=1.
- On entry the block SHALL capture pc_current into ret_pc, capture ccr_in into the flag shadow register, and load the drain counter with DRAIN_CYCLES-1.
REQ-026 In DRAIN the block SHALL assert inject_bubble and deassert pc_write_en and if_id_write_en.
- The drain counter SHALL decrement each cycle.
- The FSM SHALL go to PUSH in the cycle after the counter reads 0.
REQ-027 In PUSH the block SHALL drive mem_we=1, mem_addr=sp_val, mem_wdata=ret_pc, sp_en=1 and sp_op=0, and SHALL clear pending; next state is VEC_RD.
REQ-028 In VEC_RD the block SHALL drive mem_rd=1 and mem_addr=VEC_ADDR; next state is VEC_LD.
REQ-029 In VEC_LD the block SHALL drive pc_load=1, pc_load_val=mem_rdata and int_ack=1; next state is ISR.
REQ-030 In ISR the fetch enables SHALL be high and new interrupts SHALL be masked, but edges SHALL still set pending.
- ISR -> R_DRAIN on rti_dec=1.
- In all other states rti_dec SHALL be ignored.
REQ-031 R_DRAIN SHALL behave exactly as DRAIN (same outputs, same DRAIN_CYCLES count) and SHALL then go to POP.
REQ-032 In POP the block SHALL drive mem_rd=1, mem_addr=sp_val+1 (8-bit wrap, 8'hFF+1 = 8'h00), sp_en=1 and sp_op=1; next state is R_WAIT.
REQ-033 In R_WAIT the block SHALL capture mem_rdata into ret_pc; next state is R_LD.
REQ-034 In R_LD the block SHALL drive pc_load=1, pc_load_val=ret_pc, ccr_load=1 and ccr_val=shadow; next state is IDLE.
- A pending interrupt SHALL be evaluated in IDLE on the following cycle.
REQ-035 Outputs not named for a state SHALL be 0, except pc_write_en and if_id_write_en, which SHALL be 1 only in IDLE and ISR.
- Interrupt latency from the intr_sig edge at a boundary to int_ack SHALL be 1 (edge detect) + DRAIN_CYCLES + 3 cycles.
REQ-036 No nesting: an interrupt edge during PUSH..R_LD SHALL only set pending.

Reset
REQ-037 rst=1 at any clock edge SHALL force IDLE and clear pending, intr_prev, ret_pc, shadow and the drain counter to 0.
- During reset, pc_write_en and if_id_write_en SHALL be 1 and all other outputs 0.
- This SHALL hold when reset is asserted mid-sequence, including during PUSH, so no mem_we is issued in the reset cycle.

Verification
REQ-038 rst released; intr_sig pulses at cycle 5 with boundary=1, pc_current=8'h20, sp_val=8'hFF, mem[1]=8'h40 -> 3 cycles of inject_bubble, then a write of 8'h20 to 8'hFF with sp_en/sp_op=0, then pc_load_val=8'h40 with int_ack, then ISR.
REQ-039 In ISR, sp_val=8'hFE and rti_dec pulses with mem[8'hFF]=8'h20 and shadow=4'b0101 -> POP with mem_addr=8'hFF, then R_LD with pc_load_val=8'h20, ccr_load=1 and ccr_val=4'b0101, then IDLE.
REQ-040 intr_sig edge while in ISR -> no action until R_LD completes; the second sequence starts within 2 cycles of returning to IDLE.
REQ-041 intr_sig held high for 20 cycles -> exactly one interrupt sequence.
REQ-042 rst asserted in the PUSH cycle -> mem_we=0 on that edge, IDLE next, pending=0.
REQ-043 pending=1 with boundary=0 for 4 cycles -> FSM stays in IDLE; it enters DRAIN on the first cycle boundary=1.
